// File: rtl/rs232_tx_arbiter_if.sv
// Client write ports plus the buffered-transmitter write port of the RS232 arbiter.
// master = arbiter side, slave = clients/transmitter side.
interface rs232_tx_arbiter_if #(
    parameter int NumClients = 4
);
    logic [NumClients-1:0]   req;
    logic [8*NumClients-1:0] data_in;
    logic [NumClients-1:0]   last;
    logic [NumClients-1:0]   ack;
    logic [NumClients-1:0]   grant;
    logic                    tx_full;
    logic                    tx_wr;
    logic [7:0]              tx_data;
    logic                    timeout;

    modport master (
        input  req, data_in, last, tx_full,
        output ack, grant, tx_wr, tx_data, timeout
    );

    modport slave (
        output req, data_in, last, tx_full,
        input  ack, grant, tx_wr, tx_data, timeout
    );
endinterface

// File: rtl/rs232_tx_arbiter.sv
// Message-granular round-robin arbiter sharing one buffered RS232 transmitter.
// The owner keeps the lock until it sends a byte flagged last or stays idle for Timeout cycles.
module rs232_tx_arbiter #(
    parameter int NumClients = 4,
    parameter int Timeout    = 1024
) (
    input  logic                clk,
    input  logic                rst_n,
    rs232_tx_arbiter_if.master  bus
);
    localparam int OW = (NumClients > 1) ? $clog2(NumClients) : 1;
    localparam int CW = $clog2(Timeout);

    typedef enum logic {S_IDLE = 1'b0, S_OWN = 1'b1} state_t;

    state_t                      r_state, w_state_nxt;
    logic [OW-1:0]               r_owner, w_owner_nxt;
    logic [OW-1:0]               r_rr, w_rr_nxt;
    logic [CW-1:0]               r_cnt, w_cnt_nxt;
    logic [OW-1:0]               w_pick;
    logic [OW-1:0]               w_owner_inc;
    logic                        w_owner_req;
    logic                        w_accept;
    logic                        w_expire;
    logic [NumClients-1:0][7:0]  w_bytes;
    logic [NumClients-1:0]       w_ack;
    logic [NumClients-1:0]       w_grant;
    logic                        w_tx_wr;
    logic [7:0]                  w_tx_data;
    logic                        w_timeout;

    function automatic logic [OW-1:0] wrap_add(logic [OW-1:0] a, int b);
        int s;
        s = (int'(a) + b) % NumClients;
        return OW'(s);
    endfunction

    assign w_bytes     = bus.data_in;
    assign w_owner_req = bus.req[r_owner];
    assign w_owner_inc = wrap_add(r_owner, 1);
    assign w_accept    = (r_state == S_OWN) & w_owner_req & ~bus.tx_full;
    // Idle means owner req low; a tx_full stall with req high never counts toward release.
    assign w_expire    = (r_state == S_OWN) & ~w_owner_req & (r_cnt == CW'(Timeout - 1));

    // Highest index first so the search position closest to r_rr wins.
    always_comb begin
        w_pick = r_rr;
        for (int i = NumClients - 1; i >= 0; i--) begin
            if (bus.req[wrap_add(r_rr, i)]) w_pick = wrap_add(r_rr, i);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_owner <= '0;
            r_rr    <= '0;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_owner <= w_owner_nxt;
            r_rr    <= w_rr_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_owner_nxt = r_owner;
        w_rr_nxt    = r_rr;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            S_IDLE: begin
                w_cnt_nxt = '0;
                if (|bus.req) begin
                    w_state_nxt = S_OWN;
                    w_owner_nxt = w_pick;
                end
            end
            S_OWN: begin
                if ((w_accept && bus.last[r_owner]) || w_expire) begin
                    w_state_nxt = S_IDLE;
                    w_rr_nxt    = w_owner_inc;
                    w_cnt_nxt   = '0;
                end else if (w_owner_req) begin
                    w_cnt_nxt = '0;
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        w_ack     = '0;
        w_grant   = '0;
        w_tx_wr   = 1'b0;
        w_tx_data = 8'h00;
        w_timeout = 1'b0;
        if (r_state == S_OWN) begin
            w_grant[r_owner] = 1'b1;
            w_ack[r_owner]   = w_accept;
            w_tx_wr          = w_accept;
            w_timeout        = w_expire;
            if (w_accept) w_tx_data = w_bytes[r_owner];
        end
    end

    assign bus.ack     = w_ack;
    assign bus.grant   = w_grant;
    assign bus.tx_wr   = w_tx_wr;
    assign bus.tx_data = w_tx_data;
    assign bus.timeout = w_timeout;
endmodule

// File: tb/tb_rs232_tx_arbiter.sv
// Scoreboard bench for rs232_tx_arbiter: clients replay queued messages, expected
// (client, byte) pairs are queued in predicted service order and matched on tx_wr.
module tb_rs232_tx_arbiter;
    localparam int N  = 4;
    localparam int TO = 16;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    rs232_tx_arbiter_if #(.NumClients(N)) bus ();

    rs232_tx_arbiter #(.NumClients(N), .Timeout(TO)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int total = 0;
    int bad   = 0;

    logic [8:0] msg [N][64];
    int         rd [N];
    int         wr [N];
    logic [N-1:0] en;
    logic [9:0] expq [$];

    logic [N-1:0] s_grant, s_ack;
    logic         s_txwr, s_timeout;
    logic [7:0]   s_data;

    task automatic push(int c, logic [7:0] b, logic l, logic ex);
        msg[c][wr[c]] = {l, b};
        wr[c]++;
        if (ex) expq.push_back({2'(c), b});
    endtask

    // One clock: drive clients, sample mid-cycle, score any write, advance acked clients.
    task automatic tick();
        logic [9:0] e;
        int o;
        for (int i = 0; i < N; i++) begin
            if (en[i] && rd[i] != wr[i]) begin
                bus.req[i]             = 1'b1;
                bus.data_in[8*i +: 8]  = msg[i][rd[i]][7:0];
                bus.last[i]            = msg[i][rd[i]][8];
            end else begin
                bus.req[i]             = 1'b0;
                bus.data_in[8*i +: 8]  = 8'h00;
                bus.last[i]            = 1'b0;
            end
        end
        @(negedge clk);
        s_grant = bus.grant; s_ack = bus.ack; s_txwr = bus.tx_wr;
        s_data = bus.tx_data; s_timeout = bus.timeout;
        if (s_txwr) begin
            o = 0;
            for (int i = 0; i < N; i++) if (s_grant[i]) o = i;
            total++;
            if (expq.size() == 0) begin
                bad++;
                $display("FAIL sb_extra: got client %0d byte %02h, expected no write", o, s_data);
            end else begin
                e = expq.pop_front();
                if ({2'(o), s_data} !== e) begin
                    bad++;
                    $display("FAIL sb_byte: got client %0d byte %02h, expected client %0d byte %02h",
                             o, s_data, e[9:8], e[7:0]);
                end
            end
        end
        @(posedge clk);
        #1;
        for (int i = 0; i < N; i++) if (s_ack[i] && rd[i] != wr[i]) rd[i]++;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        @(posedge clk);
        #1;
        total++;
        if ({bus.grant, bus.ack, bus.tx_wr, bus.tx_data, bus.timeout} !== '0) begin
            bad++;
            $display("FAIL reset_outputs: grant=%b ack=%b wr=%b data=%02h to=%b, expected all 0",
                     bus.grant, bus.ack, bus.tx_wr, bus.tx_data, bus.timeout);
        end
        rst_n = 1'b1;
        tick();
        total++;
        if (s_grant !== 4'b0000) begin
            bad++;
            $display("FAIL reset_idle: grant=%b expected 0000", s_grant);
        end
    endtask

    task automatic test_single();
        logic [3:0] eg;
        int nwr = 0;
        push(0, 8'h41, 1'b0, 1'b1);
        push(0, 8'h42, 1'b0, 1'b1);
        push(0, 8'h43, 1'b1, 1'b1);
        for (int k = 0; k < 5; k++) begin
            tick();
            eg = (k >= 1 && k <= 3) ? 4'b0001 : 4'b0000;
            if (s_txwr) nwr++;
            total++;
            if ({s_grant, s_txwr} !== {eg, |eg}) begin
                bad++;
                $display("FAIL single_c%0d: grant=%b wr=%b expected grant=%b wr=%b", k, s_grant, s_txwr, eg, |eg);
            end
        end
        total++;
        if (nwr != 3) begin
            bad++;
            $display("FAIL single_count: %0d writes expected 3", nwr);
        end
    endtask

    task automatic test_two_clients();
        logic [27:0] egs = {4'h0, 4'h4, 4'h4, 4'h0, 4'h2, 4'h2, 4'h0};
        push(1, 8'hA1, 1'b0, 1'b1);
        push(1, 8'hA2, 1'b1, 1'b1);
        push(2, 8'hB1, 1'b0, 1'b1);
        push(2, 8'hB2, 1'b1, 1'b1);
        for (int k = 0; k < 7; k++) begin
            tick();
            total++;
            if ({s_grant, s_txwr} !== {egs[4*k +: 4], |egs[4*k +: 4]}) begin
                bad++;
                $display("FAIL two_c%0d: grant=%b wr=%b expected grant=%b", k, s_grant, s_txwr, egs[4*k +: 4]);
            end
        end
    endtask

    task automatic test_round_robin();
        logic [3:0] eg;
        do_reset();
        for (int m = 0; m < 8; m++) push(m % N, 8'h60 + 8'(m), 1'b1, 1'b1);
        for (int k = 0; k < 17; k++) begin
            tick();
            eg = (k % 2 == 1) ? (4'b0001 << ((k / 2) % N)) : 4'b0000;
            total++;
            if (s_grant !== eg) begin
                bad++;
                $display("FAIL rr_c%0d: grant=%b expected %b", k, s_grant, eg);
            end
        end
    endtask

    task automatic test_tx_full();
        for (int b = 0; b < 4; b++) push(1, 8'h80 + 8'(b), (b == 3), 1'b1);
        tick();
        tick();
        total++;
        if ({s_grant, s_txwr} !== {4'b0010, 1'b1}) begin
            bad++;
            $display("FAIL full_first: grant=%b wr=%b expected 0010/1", s_grant, s_txwr);
        end
        bus.tx_full = 1'b1;
        for (int k = 0; k < 5; k++) begin
            tick();
            total++;
            if ({s_grant, s_txwr, s_ack, s_timeout} !== {4'b0010, 1'b0, 4'b0000, 1'b0}) begin
                bad++;
                $display("FAIL full_stall%0d: grant=%b wr=%b ack=%b to=%b expected 0010/0/0000/0",
                         k, s_grant, s_txwr, s_ack, s_timeout);
            end
        end
        bus.tx_full = 1'b0;
        for (int k = 0; k < 4; k++) begin
            tick();
            total++;
            if ({s_grant, s_txwr} !== ((k < 3) ? {4'b0010, 1'b1} : 5'b0)) begin
                bad++;
                $display("FAIL full_resume%0d: grant=%b wr=%b", k, s_grant, s_txwr);
            end
        end
    endtask

    task automatic test_timeout();
        push(2, 8'h90, 1'b0, 1'b1);
        push(2, 8'h91, 1'b0, 1'b1);
        push(2, 8'h92, 1'b1, 1'b0);
        push(3, 8'hA0, 1'b1, 1'b1);
        en[3] = 1'b0;
        tick();
        tick();
        en[3] = 1'b1;
        en[2] = 1'b0;
        for (int k = 0; k < 5; k++) begin
            tick();
            total++;
            if ({s_grant, s_txwr, s_ack, s_timeout} !== {4'b0100, 1'b0, 4'b0000, 1'b0}) begin
                bad++;
                $display("FAIL to_gap%0d: grant=%b wr=%b ack=%b to=%b expected 0100/0/0000/0",
                         k, s_grant, s_txwr, s_ack, s_timeout);
            end
        end
        en[2] = 1'b1;
        tick();
        total++;
        if ({s_grant, s_txwr} !== {4'b0100, 1'b1}) begin
            bad++;
            $display("FAIL to_resume: grant=%b wr=%b expected 0100/1", s_grant, s_txwr);
        end
        en[2] = 1'b0;
        for (int k = 0; k < TO; k++) begin
            tick();
            total++;
            if ({s_grant, s_timeout, s_ack[3]} !== {4'b0100, (k == TO - 1), 1'b0}) begin
                bad++;
                $display("FAIL to_idle%0d: grant=%b to=%b ack3=%b expected 0100/%0d/0",
                         k, s_grant, s_timeout, s_ack[3], (k == TO - 1));
            end
        end
        rd[2] = wr[2];
        en[2] = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            total++;
            if ({s_grant, s_timeout} !== ((k == 1) ? {4'b1000, 1'b0} : 5'b0)) begin
                bad++;
                $display("FAIL to_regrant%0d: grant=%b to=%b", k, s_grant, s_timeout);
            end
        end
    endtask

    task automatic test_reset_mid();
        logic [19:0] egs = {4'h0, 4'h8, 4'h0, 4'h2, 4'h0};
        push(2, 8'hC0, 1'b0, 1'b1);
        push(2, 8'hC1, 1'b0, 1'b0);
        push(2, 8'hC2, 1'b1, 1'b0);
        tick();
        tick();
        total++;
        if (s_grant !== 4'b0100) begin
            bad++;
            $display("FAIL rst_own: grant=%b expected 0100", s_grant);
        end
        rst_n = 1'b0;
        #1;
        total++;
        if ({bus.grant, bus.tx_wr, bus.ack} !== '0) begin
            bad++;
            $display("FAIL rst_async: grant=%b wr=%b ack=%b expected 0", bus.grant, bus.tx_wr, bus.ack);
        end
        rd[2] = wr[2];
        push(1, 8'hD1, 1'b1, 1'b1);
        push(3, 8'hD3, 1'b1, 1'b1);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int k = 0; k < 5; k++) begin
            tick();
            total++;
            if (s_grant !== egs[4*k +: 4]) begin
                bad++;
                $display("FAIL rst_after%0d: grant=%b expected %b", k, s_grant, egs[4*k +: 4]);
            end
        end
    endtask

    initial begin
        bus.req = '0; bus.data_in = '0; bus.last = '0; bus.tx_full = 1'b0;
        en = '1;
        for (int i = 0; i < N; i++) begin rd[i] = 0; wr[i] = 0; end
        test_reset();
        test_single();
        test_two_clients();
        test_round_robin();
        test_tx_full();
        test_timeout();
        test_reset_mid();
        total++;
        if (expq.size() != 0) begin
            bad++;
            $display("FAIL sb_left: %0d expected bytes never written, expected 0", expq.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
